// File: rtl/intdiv_seqctl.sv
// Sequencing controller for an external combinational signed divider array.
// Registers operands, waits LAT cycles for the array to settle, then holds the result until it is taken.
//
// state | meaning
// IDLE  | waiting for a request; in_ready=1
// BUSY  | operands on div_x/div_y, counting down the array settle time
// DONE  | result registers valid; out_valid=1 until out_ready
module intdiv_seqctl #(
  parameter int N   = 32,
  parameter int LAT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N-1:0] div_x,
  output logic [N-1:0] div_y,
  input  logic [N-1:0] div_z,
  input  logic [N-1:0] div_r,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] z,
  output logic [N-1:0] r,
  output logic         dz,
  output logic         ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0]   CNT_INIT = 4'(LAT - 1);
  localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         op_ld;
  logic [N-1:0] z_d, r_d;
  logic         dz_d, ovf_d;
  logic         y_zero, ovf_case;

  // Exceptions are detected by pure equality on the request operands.
  assign y_zero   = (y == '0);
  assign ovf_case = (x == MOST_NEG) && (y == '1);

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_ld   = 1'b0;
    z_d     = z;
    r_d     = r;
    dz_d    = dz;
    ovf_d   = ovf;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      dz_d    = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_ld = 1'b1;
            if (y_zero) begin
              state_d = DONE;
              z_d     = '1;
              r_d     = x;
              dz_d    = 1'b1;
              ovf_d   = 1'b0;
            end else if (ovf_case) begin
              state_d = DONE;
              z_d     = x;
              r_d     = '0;
              dz_d    = 1'b0;
              ovf_d   = 1'b1;
            end else begin
              state_d = BUSY;
              cnt_d   = CNT_INIT;
            end
          end
        end
        BUSY: begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            state_d = DONE;
            z_d     = div_z;
            r_d     = div_r;
            dz_d    = 1'b0;
            ovf_d   = 1'b0;
          end
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_x <= '0;
      div_y <= '0;
      z     <= '0;
      r     <= '0;
      dz    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (op_ld) begin
        div_x <= x;
        div_y <= y;
      end
      z   <= z_d;
      r   <= r_d;
      dz  <= dz_d;
      ovf <= ovf_d;
    end
  end

endmodule

// File: tb/tb_intdiv_seqctl.sv
// Scoreboard bench for intdiv_seqctl with a behavioural divider array model.
// Stimulus pushes hand-computed results; a negedge monitor pops them on each output handshake.
module tb_intdiv_seqctl;

  localparam int N   = 32;
  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         flush, in_valid, in_ready, out_valid, out_ready, dz, ovf;
  logic [N-1:0] x, y, div_x, div_y, div_z, div_r, z, r;

  typedef struct packed {
    logic [N-1:0] z;
    logic [N-1:0] r;
    logic         dz;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  intdiv_seqctl #(.N(N), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y),
    .div_x(div_x), .div_y(div_y), .div_z(div_z), .div_r(div_r),
    .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .r(r), .dz(dz), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Divider array model; exceptional operand pairs are guarded so the simulator never traps.
  always_comb begin
    if (div_y == '0 || (div_x == 32'h80000000 && div_y == '1)) begin
      div_z = '0;
      div_r = '0;
    end else begin
      div_z = $signed(div_x) / $signed(div_y);
      div_r = $signed(div_x) % $signed(div_y);
    end
  end

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      check("result_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("sb_z", z, e.z);
        check("sb_r", r, e.r);
        check("sb_dz", 32'(dz), 32'(e.dz));
        check("sb_ovf", 32'(ovf), 32'(e.ovf));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_div_x", div_x, 32'd0);
    check("rst_div_y", div_y, 32'd0);
    check("rst_z", z, 32'd0);
    check("rst_r", r, 32'd0);
    check("rst_dz", 32'(dz), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
  endtask

  // One request; while waiting and holding, in_valid stays high with different operands.
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] ez, input logic [N-1:0] er,
                       input logic edz, input logic eovf, input int lat, input int hold);
    int n;
    sb.push_back('{ez, er, edz, eovf});
    x = a; y = b; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    check("accept_in_ready", 32'(in_ready), 32'd0);
    check("accept_div_x", div_x, a);
    check("accept_div_y", div_y, b);
    x = ~a; y = ~b;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check("latency", 32'(n), 32'(lat));
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_z", z, ez);
      check("hold_r", r, er);
      check("hold_dz", 32'(dz), 32'(edz));
      check("hold_ovf", 32'(ovf), 32'(eovf));
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_out_valid", 32'(out_valid), 32'd0);
    check("release_z_held", z, ez);
    check("no_sample_div_x", div_x, a);
    check("no_sample_div_y", div_y, b);
  endtask

  initial begin
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals();
    rst_n = 1'b1;

    do_op(32'd30, 32'd7, 32'd4, 32'd2, 1'b0, 1'b0, LAT, 0);
    do_op(32'hFFFFFF88, 32'd11, 32'hFFFFFFF6, 32'hFFFFFFF6, 1'b0, 1'b0, LAT, 5);
    do_op(32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, 1'b0, 0, 2);
    do_op(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 1'b1, 0, 1);

    // Flush on the second BUSY cycle: result registers and operands keep their old values.
    x = 32'd100; y = 32'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_in_ready", 32'(in_ready), 32'd1);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_dz", 32'(dz), 32'd0);
    check("flush_ovf", 32'(ovf), 32'd0);
    check("flush_z_kept", z, 32'h80000000);
    check("flush_r_kept", r, 32'd0);
    check("flush_div_x_kept", div_x, 32'd100);
    check("flush_div_y_kept", div_y, 32'd7);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("flush_no_result", 32'(out_valid), 32'd0);
    end
    out_ready = 1'b0;
    do_op(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0, LAT, 0);

    // Reset in the middle of BUSY, with in_valid held high on new operands.
    x = 32'd77; y = 32'd5; in_valid = 1'b1;
    tick();
    x = 32'd1234; y = 32'd17;
    tick();
    check("busy_in_ready", 32'(in_ready), 32'd0);
    check("busy_div_x", div_x, 32'd77);
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    in_valid = 1'b0;
    repeat (2) tick();
    check("rst_no_result", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    do_op(32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, LAT, 0);

    repeat (2) tick();
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/intdiv_seqctl.md
INTDIV_SEQCTL -- requirements
Module: intdiv_seqctl

Interface
REQ-001 Parameter N, default 32: operand/result width in bits, two's complement.
REQ-002 Parameter LAT, default 4, legal range 1..15: clock cycles allowed for the combinational divider array to settle.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 flush  input  1  synchronous abort; returns the block to IDLE.
REQ-006 in_valid  input  1  request operands present on x and y.
REQ-007 in_ready  output  1  block can accept a request.
REQ-008 x  input  N  dividend, signed.
REQ-009 y  input  N  divisor, signed.
REQ-010 div_x  output  N  registered dividend driven to the divider array.
REQ-011 div_y  output  N  registered divisor driven to the divider array.
REQ-012 div_z  input  N  quotient from the divider array (truncated toward zero).
REQ-013 div_r  input  N  remainder from the divider array (sign of dividend).
REQ-014 out_valid  output  1  result registers hold a valid result.
REQ-015 out_ready  input  1  consumer accepts the result.
REQ-016 z  output  N  registered quotient.
REQ-017 r  output  N  registered remainder.
REQ-018 dz  output  1  divide-by-zero flag for the current result.
REQ-019 ovf  output  1  overflow flag (most-negative / -1) for the current result.

Function
REQ-020 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-021 in_ready SHALL be 1 only in IDLE and SHALL be decoded from the state alone, with no dependence on in_valid.
REQ-022 out_valid SHALL be 1 only in DONE.
REQ-023 An IDLE edge with in_valid=1 SHALL be an accept: x and y load into div_x and div_y.
REQ-024 On accept with y==0, the block SHALL enter DONE and load z={N{1}}, r=x, dz=1, ovf=0; it SHALL NOT enter BUSY.
REQ-025 On accept with x==2^(N-1) (most negative) and y=={N{1}} (-1), the block SHALL enter DONE and load z=x, r=0, dz=0, ovf=1; it SHALL NOT enter BUSY.
REQ-026 On any other accept, the block SHALL enter BUSY with the down-counter loaded to LAT-1.
REQ-027 In BUSY with counter!=0, each edge SHALL decrement the counter; div_x and div_y SHALL stay stable.
REQ-028 In BUSY with counter==0, the edge SHALL capture z=div_z, r=div_r, dz=0, ovf=0 and enter DONE.
REQ-029 Normal latency: with the accept on edge k, out_valid SHALL rise after edge k+LAT.
REQ-030 Exception latency (REQ-024, REQ-025): out_valid SHALL rise after edge k.
REQ-031 In DONE, an edge with out_ready=1 SHALL return the block to IDLE; z, r, dz and ovf SHALL hold their values until the next load.
REQ-032 In DONE with out_ready=0, z, r, dz and ovf SHALL stay stable for any number of cycles.
REQ-033 Only one operation SHALL be in flight at a time; a result SHALL NOT be overwritten before its out_valid handshake completes.
REQ-034 in_valid asserted in BUSY or DONE SHALL be ignored; x and y SHALL NOT be sampled.
REQ-035 flush=1 SHALL force IDLE on the next edge from any state, take priority over accept, capture and out handshake, and clear out_valid, dz, ovf and the counter.
REQ-036 A flush SHALL leave z, r, div_x and div_y unchanged.
REQ-037 No arithmetic SHALL be performed in this block; exception detection SHALL use only equality compares on x and y.

Reset
REQ-038 While rst_n=0, the block SHALL hold: state=IDLE, counter=0, div_x=0, div_y=0, z=0, r=0, dz=0, ovf=0, out_valid=0.
REQ-039 Reset asserted in any state, including mid-BUSY, SHALL abandon the operation with no output handshake.
REQ-040 The first edge after rst_n rises SHALL be able to accept a request.

Verification
REQ-041 The bench SHALL cover: N=32, LAT=4, x=30, y=7, accept at edge k -> out_valid after edge k+4, z=4, r=2, dz=0, ovf=0.
REQ-042 The bench SHALL cover: x=-120, y=11 -> z=-10, r=-10, then out_ready held 0 for 5 cycles -> outputs and out_valid stable.
REQ-043 The bench SHALL cover: x=5, y=0 -> out_valid after the accept edge, dz=1, z=32'hFFFFFFFF, r=5, ovf=0, no BUSY cycle.
REQ-044 The bench SHALL cover: x=32'h80000000, y=32'hFFFFFFFF -> ovf=1, z=32'h80000000, r=0, dz=0.
REQ-045 The bench SHALL cover: flush pulse on the second BUSY cycle -> IDLE next edge, out_valid never asserted, in_ready=1, and the next request x=9, y=3 gives z=3, r=0.
REQ-046 The bench SHALL cover: rst_n low mid-BUSY -> all outputs at reset values immediately; in_valid held during BUSY/DONE is never sampled.
